// File: rtl/taylor_pkg.sv
// taylor_pkg -- shared definitions for the angle range reducer and the
// downstream cosine (Taylor series) stage.
//   ANGLE_W / FRAC_BITS : default angle width and fixed-point fraction bits
//   TWO_PI / PI / HALF_PI : angle constants at a 2^BASE_FRAC scale
//   K_MAX               : highest shift used by the range reduction
//   state_e             : reducer FSM state encoding
package taylor_pkg;

   localparam int ANGLE_W   = 24;
   localparam int FRAC_BITS = 10;

   // The constants below are expressed at this scale (1024).
   localparam int BASE_FRAC = 10;
   localparam int TWO_PI    = 6434;
   localparam int PI        = 3217;
   localparam int HALF_PI   = 1608;

   // Reduction subtracts TWO_PI<<k for k = K_MAX..0, one step per cycle.
   localparam int K_MAX     = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      FOLD   = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/angle_range_reducer.sv
// angle_range_reducer -- maps a signed fixed-point angle onto [0, HALF_PI]
// plus a negate flag, so a downstream cosine stage only has to cover the
// first quadrant: cos(x) = +/- cos(angle_out).
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low reset
//   start      : request pulse, sampled only while idle
//   angle_in   : signed angle (radians, FRAC_BITS fraction bits)
//   busy_out   : high whenever a request is in flight
//   ready_out  : one-cycle result strobe (drives the cosine stage start)
//   angle_out  : reduced angle, held until the next result
//   negate_out : cosine result must be negated, held with angle_out
module angle_range_reducer #(
   parameter int ANGLE_W   = taylor_pkg::ANGLE_W,
   parameter int FRAC_BITS = taylor_pkg::FRAC_BITS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [ANGLE_W-1:0] angle_in,
   output logic               busy_out,
   output logic               ready_out,
   output logic [ANGLE_W-1:0] angle_out,
   output logic               negate_out
);
   import taylor_pkg::*;

   localparam int KW = $clog2(K_MAX + 1);
   // Wide enough to hold TWO_PI << K_MAX without truncation.
   localparam int SW = ANGLE_W + K_MAX + 1;

   // Rescale the 1024-based constants to this instance's fraction width.
   localparam longint TWO_PI_S  = (longint'(TWO_PI)  << FRAC_BITS) >> BASE_FRAC;
   localparam longint PI_S      = (longint'(PI)      << FRAC_BITS) >> BASE_FRAC;
   localparam longint HALF_PI_S = (longint'(HALF_PI) << FRAC_BITS) >> BASE_FRAC;

   localparam logic [SW-1:0]      TWO_PI_W  = SW'(TWO_PI_S);
   localparam logic [ANGLE_W-1:0] TWO_PI_A  = ANGLE_W'(TWO_PI_S);
   localparam logic [ANGLE_W-1:0] PI_A      = ANGLE_W'(PI_S);
   localparam logic [ANGLE_W-1:0] HALF_PI_A = ANGLE_W'(HALF_PI_S);

   localparam logic [ANGLE_W-1:0] S_MIN = {1'b1, {(ANGLE_W-1){1'b0}}};
   localparam logic [ANGLE_W-1:0] S_MAX = {1'b0, {(ANGLE_W-1){1'b1}}};

   state_e             state_q, state_d;
   logic [ANGLE_W-1:0] a_q, a_d;
   logic [KW-1:0]      k_q, k_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic               negate_q, negate_d;
   logic               ready_q, ready_d;

   logic [ANGLE_W-1:0] a_abs;
   logic [SW-1:0]      step;
   logic               step_ge;
   logic [ANGLE_W-1:0] a1;

   // |angle_in|; the most negative value has no positive twin, so clamp it.
   always_comb begin
      a_abs = angle_in;
      if (angle_in == S_MIN)
         a_abs = S_MAX;
      else if (angle_in[ANGLE_W-1])
         a_abs = (~angle_in) + ANGLE_W'(1);
   end

   // Binary long-division style remainder: one conditional subtract per bit
   // of the quotient, so 11 steps cover any a < TWO_PI * 2^11.
   always_comb begin
      step    = TWO_PI_W << k_q;
      step_ge = {{(SW-ANGLE_W){1'b0}}, a_q} >= step;
   end

   // a in [0, TWO_PI): mirror the lower half-turn, then fold about HALF_PI.
   always_comb begin
      a1 = (a_q >= PI_A) ? (TWO_PI_A - a_q) : a_q;
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      k_d      = k_q;
      angle_d  = angle_q;
      negate_d = negate_q;
      ready_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_abs;
               k_d     = KW'(K_MAX);
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            if (step_ge)
               a_d = a_q - step[ANGLE_W-1:0];
            if (k_q == '0)
               state_d = FOLD;
            else
               k_d = k_q - KW'(1);
         end
         FOLD: begin
            if (a1 > HALF_PI_A) begin
               angle_d  = PI_A - a1;
               negate_d = 1'b1;
            end else begin
               angle_d  = a1;
               negate_d = 1'b0;
            end
            // Registered, so the strobe lands in the DONE cycle.
            ready_d = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         k_q      <= '0;
         angle_q  <= '0;
         negate_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         k_q      <= k_d;
         angle_q  <= angle_d;
         negate_q <= negate_d;
         ready_q  <= ready_d;
      end
   end

   assign busy_out   = (state_q != IDLE);
   assign ready_out  = ready_q;
   assign angle_out  = angle_q;
   assign negate_out = negate_q;

endmodule

// File: tb/tb_angle_range_reducer.sv
// tb_angle_range_reducer -- directed self-checking bench for
// angle_range_reducer with hand-computed expected results.
module tb_angle_range_reducer;

   localparam int W = 24;

   logic         clock;
   logic         reset;
   logic         start;
   logic [W-1:0] angle_in;
   logic         busy_out;
   logic         ready_out;
   logic [W-1:0] angle_out;
   logic         negate_out;

   int checks   = 0;
   int failures = 0;

   angle_range_reducer #(.ANGLE_W(W), .FRAC_BITS(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .angle_in  (angle_in),
      .busy_out  (busy_out),
      .ready_out (ready_out),
      .angle_out (angle_out),
      .negate_out(negate_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one request; lat = number of edges after the sampling edge until
   // ready_out is seen (99 if it never arrives within the bound).
   task automatic do_req(input logic [W-1:0] ang, output int lat);
      @(negedge clock);
      angle_in = ang;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clock);
         #1;
         if (ready_out) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run_vec(input string tag, input logic [W-1:0] ang,
                          input int exp_ang, input int exp_neg);
      int lat;
      do_req(ang, lat);
      check({tag, ".latency"}, lat, 12);
      check({tag, ".angle"}, angle_out, exp_ang);
      check({tag, ".negate"}, negate_out, exp_neg);
      @(posedge clock);
      #1;
      check({tag, ".ready_drop"}, ready_out, 0);
      check({tag, ".hold"}, angle_out, exp_ang);
   endtask

   initial begin
      int lat;
      int pulses;
      int pulse_ang;

      reset    = 1'b0;
      start    = 1'b0;
      angle_in = '0;
      #12;
      check("reset.busy", busy_out, 0);
      check("reset.ready", ready_out, 0);
      check("reset.angle", angle_out, 0);
      check("reset.negate", negate_out, 0);
      @(negedge clock);
      reset = 1'b1;

      run_vec("v1536", 24'd1536, 1536, 0);
      run_vec("v3072", 24'd3072, 145, 1);
      run_vec("v4800", 24'd4800, 1583, 1);
      run_vec("vneg1536", -24'sd1536, 1536, 0);
      run_vec("v7000", 24'd7000, 566, 0);
      run_vec("vmin", 24'h800000, 1329, 0);
      run_vec("vpi", 24'd3217, 0, 1);
      run_vec("vhalfpi", 24'd1608, 1608, 0);
      run_vec("v3pi2", 24'd4826, 1608, 0);
      run_vec("vzero", 24'd0, 0, 0);

      // Busy while in flight; start during DONE is dropped.
      do_req(24'd1536, lat);
      check("done_start.latency", lat, 12);
      start    = 1'b1;
      angle_in = 24'd3072;
      @(posedge clock);
      #1 start = 1'b0;
      check("done_start.busy", busy_out, 0);
      check("done_start.angle", angle_out, 1536);

      // Second start during REDUCE must be ignored.
      @(negedge clock);
      angle_in = 24'd1536;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("overlap.busy", busy_out, 1);
      angle_in = 24'd3072;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      pulses    = 0;
      pulse_ang = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clock);
         #1;
         if (ready_out) begin
            pulses++;
            pulse_ang = int'(angle_out);
         end
      end
      check("overlap.pulses", pulses, 1);
      check("overlap.angle", pulse_ang, 1536);

      // Reset in the fifth REDUCE cycle aborts the request.
      @(negedge clock);
      angle_in = 24'd4800;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("midreset.busy", busy_out, 0);
      check("midreset.angle", angle_out, 0);
      check("midreset.negate", negate_out, 0);
      check("midreset.ready", ready_out, 0);
      pulses = 0;
      for (int n = 0; n < 15; n++) begin
         @(posedge clock);
         #1;
         if (ready_out) pulses++;
      end
      check("midreset.no_pulse", pulses, 0);
      @(negedge clock);
      reset = 1'b1;
      run_vec("post_reset", 24'd1536, 1536, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/angle_range_reducer.md
ANGLE_RANGE_REDUCER -- requirements
Module: angle_range_reducer

Interface
REQ-001 The block SHALL have parameter ANGLE_W, default 24: width of all angle ports.
REQ-002 The block SHALL have parameter FRAC_BITS, default 10: number of fractional bits of the fixed-point angle format.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request pulse; it SHALL be sampled only in IDLE.
REQ-006 The block SHALL have port angle_in, input, ANGLE_W bits: signed two's-complement angle in radians, with FRAC_BITS fractional bits.
REQ-007 The block SHALL have port busy_out, output, 1 bit: high in every state other than IDLE.
REQ-008 The block SHALL have port ready_out, output, 1 bit: single-cycle pulse marking a valid result; it SHALL drive the downstream cosine stage's start.
REQ-009 The block SHALL have port angle_out, output, ANGLE_W bits: unsigned reduced angle in [0, HALF_PI], in the same fixed-point format.
REQ-010 The block SHALL have port negate_out, output, 1 bit: when high, the downstream cosine result is to be negated.

Function
REQ-011 Constants SHALL be TWO_PI=6434, PI=3217 and HALF_PI=1608 (scale 1024).
REQ-012 The FSM SHALL have the states IDLE, REDUCE, FOLD and DONE.
REQ-013 IDLE with start=1 SHALL capture a=|angle_in|, saturate -2^(ANGLE_W-1) to 2^(ANGLE_W-1)-1, set k=10 and go to REDUCE.
REQ-014 Each REDUCE cycle SHALL apply: if a >= TWO_PI<<k then a -= TWO_PI<<k; k==0 then goes to FOLD, else k decrements.
REQ-015 REDUCE SHALL take exactly 11 cycles, and on exit 0 <= a < TWO_PI SHALL hold.
REQ-016 FOLD SHALL be a single cycle.
REQ-017 In FOLD, a1 SHALL equal TWO_PI-a if a >= PI, else a.
REQ-018 In FOLD, if a1 > HALF_PI then angle_out SHALL be PI-a1 with negate_out=1, else angle_out SHALL be a1 with negate_out=0.
REQ-019 From FOLD the FSM SHALL go to DONE.
REQ-020 DONE SHALL assert ready_out for exactly one cycle and return to IDLE.
REQ-021 Latency: ready_out SHALL be high in the cycle after the 12th rising edge following the edge that samples start.
REQ-022 angle_out and negate_out SHALL be registered and SHALL hold their values until the next result is produced.
REQ-023 start SHALL be ignored while busy_out=1, with no queuing.
REQ-024 A start in the same cycle as ready_out SHALL be ignored, since the state is DONE; a new request is accepted from the next cycle.
REQ-025 Boundary: a == PI SHALL fold to a1=PI, giving angle_out=0 and negate_out=1.
REQ-026 Boundary: a1 == HALF_PI SHALL produce no negation.

Reset
REQ-027 While reset=0, the state SHALL be IDLE, and a, k, angle_out, negate_out, ready_out and busy_out SHALL all be 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abort the computation with no ready_out pulse; the first start after release SHALL be processed normally.

Structure
REQ-029 The shared package taylor_pkg SHALL hold ANGLE_W, FRAC_BITS, TWO_PI, PI, HALF_PI and the FSM state enum, for reuse by the cosine stage.
REQ-030 The block SHALL be a single module with no sub-module; the compare-and-subtract is inline.

Verification
REQ-031 angle_in=1536 SHALL give angle_out=1536, negate_out=0, with ready_out at the required latency (edge 12).
REQ-032 angle_in=3072 SHALL give angle_out=145, negate_out=1; and angle_in=4800 SHALL give angle_out=1583, negate_out=1.
REQ-033 angle_in=-1536 SHALL give angle_out=1536, negate_out=0; and angle_in=7000 SHALL give angle_out=566, negate_out=0.
REQ-034 angle_in=-8388608 SHALL saturate to 8388607, giving remainder 5105 and then angle_out=1329, negate_out=0.
REQ-035 A start pulse issued during REDUCE SHALL produce exactly one ready_out, for the first request only.
REQ-036 Reset asserted at REDUCE cycle 5 SHALL zero all outputs with no ready_out; a following start with angle_in=1536 SHALL yield 1536.
